// File: rtl/cla_seq_adder_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_seq_adder_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_seq_adder_cla4.sv
// 4-bit carry-lookahead slice; purely combinational.
module cla_seq_adder_cla4
  import cla_seq_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum_c,
  output logic             cout_c
);

  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W:0]   c;

  // Generate/propagate terms and flattened lookahead carries.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum_c  = p ^ c[NIB_W-1:0];
    cout_c = c[NIB_W];
  end

endmodule

// File: rtl/cla_seq_adder.sv
// Nibble-serial adder/subtractor: one cla4 slice reused LSB-first with a registered carry.
module cla_seq_adder
  import cla_seq_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned IDX_W = $clog2(NIB);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_next;
  logic               carry;
  logic               carry_next;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   a_next;
  logic [WIDTH-1:0]   beff_reg;
  logic [WIDTH-1:0]   beff_next;
  logic [WIDTH-1:0]   sum_next;
  logic               cout_next;
  logic               ovf_next;

  logic [NIB_W-1:0]   slice_a;
  logic [NIB_W-1:0]   slice_b;
  logic [NIB_W-1:0]   slice_sum;
  logic               slice_cout;

  // Select the current nibble of each operand for the shared slice.
  always_comb begin
    slice_a = a_reg[NIB_W*idx +: NIB_W];
    slice_b = beff_reg[NIB_W*idx +: NIB_W];
  end

  cla_seq_adder_cla4 u_cla4 (
    .a      (slice_a),
    .b      (slice_b),
    .cin    (carry),
    .sum_c  (slice_sum),
    .cout_c (slice_cout)
  );

  // Next-state and datapath next values; everything holds by default.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    carry_next = carry;
    a_next     = a_reg;
    beff_next  = beff_reg;
    sum_next   = sum;
    cout_next  = cout;
    ovf_next   = ovf;
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_next     = a;
          beff_next  = sub ? ~b : b;
          carry_next = sub ? 1'b1 : cin;
          sum_next   = '0;
          idx_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        sum_next[NIB_W*idx +: NIB_W] = slice_sum;
        carry_next = slice_cout;
        if (idx == IDX_LAST) begin
          idx_next   = '0;
          cout_next  = slice_cout;
          ovf_next   = (a_reg[WIDTH-1] == beff_reg[WIDTH-1]) &
                       (slice_sum[NIB_W-1] != a_reg[WIDTH-1]);
          state_next = DONE;
        end else begin
          idx_next = idx + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers and handshake flags decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      beff_reg  <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      idx       <= idx_next;
      carry     <= carry_next;
      a_reg     <= a_next;
      beff_reg  <= beff_next;
      sum       <= sum_next;
      cout      <= cout_next;
      ovf       <= ovf_next;
      in_ready  <= (state_next == IDLE);
      busy      <= (state_next != IDLE);
      out_valid <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder: vector table plus handshake, reset and throughput sequences.
module tb_cla_seq_adder;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    res_t             exp;
  } vec_t;

  res_t exp_q[$];
  int   res_cyc[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  cla_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t mkres(input logic [WIDTH-1:0] s, input logic co, input logic ov);
    res_t r;
    r.sum  = s;
    r.cout = co;
    r.ovf  = ov;
    return r;
  endfunction

  function automatic vec_t mkvec(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c, input logic s, input res_t e);
    vec_t v;
    v.a   = x;
    v.b   = y;
    v.cin = c;
    v.sub = s;
    v.exp = e;
    return v;
  endfunction

  // Whole-word reference arithmetic.
  function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c, input logic s);
    logic [WIDTH-1:0] be;
    logic [WIDTH:0]   full;
    res_t             r;
    be     = s ? ~y : y;
    full   = {1'b0, x} + {1'b0, be} + (WIDTH+1)'(s ? 1'b1 : c);
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (x[WIDTH-1] == be[WIDTH-1]) && (r.sum[WIDTH-1] != x[WIDTH-1]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic c, input logic s, input res_t e, input bit push);
    wait_ready();
    a        = x;
    b        = y;
    cin      = c;
    sub      = s;
    in_valid = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: compare every accepted result against the queue head.
  always @(negedge clk) begin : monitor
    res_t e;
    if (!rst && out_valid && out_ready) begin
      chk("result_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("res_sum",  32'(sum),  32'(e.sum));
        chk("res_cout", 32'(cout), 32'(e.cout));
        chk("res_ovf",  32'(ovf),  32'(e.ovf));
      end
      res_cyc.push_back(cyc);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t vecs[12];
    logic [WIDTH-1:0] rx;
    logic [WIDTH-1:0] ry;
    logic             rc;
    logic             rs;
    int               n;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;

    vecs[0] = mkvec(16'h1234, 16'h0FED, 1'b0, 1'b0, mkres(16'h2221, 1'b0, 1'b0));
    vecs[1] = mkvec(16'hFFFF, 16'h0001, 1'b0, 1'b0, mkres(16'h0000, 1'b1, 1'b0));
    vecs[2] = mkvec(16'h7FFF, 16'h0001, 1'b0, 1'b0, mkres(16'h8000, 1'b0, 1'b1));
    vecs[3] = mkvec(16'h0005, 16'h0007, 1'b1, 1'b1, mkres(16'hFFFE, 1'b0, 1'b0));
    vecs[4] = mkvec(16'h8000, 16'h0001, 1'b0, 1'b1, mkres(16'h7FFF, 1'b1, 1'b1));
    vecs[5] = mkvec(16'h00FF, 16'h0000, 1'b1, 1'b0, mkres(16'h0100, 1'b0, 1'b0));
    vecs[6] = mkvec(16'h0007, 16'h0005, 1'b0, 1'b1, mkres(16'h0002, 1'b1, 1'b0));
    vecs[7] = mkvec(16'h8000, 16'h8000, 1'b0, 1'b0, mkres(16'h0000, 1'b1, 1'b1));
    for (int i = 8; i < 12; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      vecs[i] = mkvec(rx, ry, rc, rs, model(rx, ry, rc, rs));
    end

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sum",       32'(sum),       32'd0);
    chk("rst_cout",      32'(cout),      32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // First command: latency and RUN flags.
    @(posedge clk); #1;
    a        = 16'h1234;
    b        = 16'h0FED;
    cin      = 1'b0;
    sub      = 1'b0;
    in_valid = 1'b1;
    exp_q.push_back(mkres(16'h2221, 1'b0, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("run_busy",     32'(busy),     32'd1);
    chk("run_in_ready", 32'(in_ready), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk("lat_early_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    chk("lat_valid", 32'(out_valid), 32'd1);
    drain();

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].exp, 1'b1);
      drain();
    end

    // Backpressure with a new command waiting.
    out_ready = 1'b0;
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, mkres(16'h8000, 1'b0, 1'b1), 1'b1);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    a        = 16'hAAAA;
    b        = 16'h1111;
    cin      = 1'b1;
    sub      = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("bp_sum",      32'(sum),       32'h8000);
      chk("bp_cout",     32'(cout),      32'd0);
      chk("bp_ovf",      32'(ovf),       32'd1);
      chk("bp_in_ready", 32'(in_ready),  32'd0);
      chk("bp_valid",    32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    exp_q.push_back(mkres(16'hBBBC, 1'b0, 1'b0));
    @(posedge clk); #1;
    chk("bp_idle_in_ready", 32'(in_ready),  32'd1);
    chk("bp_idle_valid",    32'(out_valid), 32'd0);
    chk("bp_sum_kept",      32'(sum),       32'h8000);
    @(posedge clk); #1;
    chk("bp_accept_busy",   32'(busy),      32'd1);
    in_valid = 1'b0;
    drain();

    // Reset while RUN at nibble index 2.
    wait_ready();
    a        = 16'h1111;
    b        = 16'h2222;
    cin      = 1'b0;
    sub      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy",  32'(busy),      32'd0);
    chk("mid_rst_sum",   32'(sum),       32'd0);
    chk("mid_rst_cout",  32'(cout),      32'd0);
    chk("mid_rst_ovf",   32'(ovf),       32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    issue(16'h0001, 16'h0001, 1'b0, 1'b0, mkres(16'h0002, 1'b0, 1'b0), 1'b1);
    drain();

    // Back-to-back with in_valid and out_ready held high.
    res_cyc.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ready();
      case (k)
        0: begin a = 16'h0010; b = 16'h0020; cin = 1'b0; sub = 1'b0;
                 exp_q.push_back(mkres(16'h0030, 1'b0, 1'b0)); end
        1: begin a = 16'h0100; b = 16'h0001; cin = 1'b0; sub = 1'b1;
                 exp_q.push_back(mkres(16'h00FF, 1'b1, 1'b0)); end
        default: begin a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0;
                 exp_q.push_back(mkres(16'hFFFF, 1'b1, 1'b0)); end
      endcase
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    repeat (8) @(posedge clk);
    #1;
    chk("b2b_count", 32'(res_cyc.size()), 32'd3);
    if (res_cyc.size() == 3) begin
      for (int k = 1; k < 3; k++) begin
        chk("b2b_spacing", 32'(res_cyc[k] - res_cyc[k-1]), 32'd6);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
